// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// Define MD_MADD_EN to enable madd/maddu (ops 6/7); otherwise they are NOPs.
module md_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e        state_q, state_d;
   logic [4:0]    count_q, count_d;
   logic [2:0]    op_q, op_d;
   logic [31:0]   a_q, a_d, b_q, b_d;
   logic [31:0]   hi_q, hi_d, lo_q, lo_d;

   logic signed [63:0] prod_s;
   logic [63:0]        prod_u;
   logic signed [31:0] quot_s, rem_s;
   logic [63:0]        result;

   // Result is formed from latched operands and only committed on the final edge.
   always_comb begin
      prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
      prod_u = {32'd0, a_q} * {32'd0, b_q};
      quot_s = $signed(a_q) / $signed(b_q);
      rem_s  = $signed(a_q) % $signed(b_q);
      result = prod_u;
      case (op_q)
         3'd0: result = prod_s;
         3'd1: result = prod_u;
         3'd2: begin
            if (b_q == 32'd0) begin
               result = {a_q, 32'hFFFF_FFFF};
            end else if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
               result = {32'd0, 32'h8000_0000};
            end else begin
               result = {rem_s, quot_s};
            end
         end
         3'd3: begin
            if (b_q == 32'd0) begin
               result = {a_q, 32'hFFFF_FFFF};
            end else begin
               result = {a_q % b_q, a_q / b_q};
            end
         end
         3'd6:    result = {hi_q, lo_q} + prod_s;
         3'd7:    result = {hi_q, lo_q} + prod_u;
         default: result = prod_u;
      endcase
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               case (op)
                  3'd0, 3'd1: begin
                     state_d = StRun;
                     count_d = 5'(MULT_CYCLES);
                     op_d    = op;
                     a_d     = rs_val;
                     b_d     = rt_val;
                  end
                  3'd2, 3'd3: begin
                     state_d = StRun;
                     count_d = 5'(DIV_CYCLES);
                     op_d    = op;
                     a_d     = rs_val;
                     b_d     = rt_val;
                  end
                  3'd4: hi_d = rs_val;
                  3'd5: lo_d = rs_val;
                  3'd6, 3'd7: begin
`ifdef MD_MADD_EN
                     state_d = StRun;
                     count_d = 5'(MULT_CYCLES);
                     op_d    = op;
                     a_d     = rs_val;
                     b_d     = rt_val;
`endif
                  end
                  default: ;
               endcase
            end
         end
         StRun: begin
            // start is ignored here; the hazard unit never issues one while busy.
            if (count_q == 5'd1) begin
               state_d = StIdle;
               count_d = 5'd0;
               hi_d    = result[63:32];
               lo_d    = result[31:0];
            end else begin
               count_d = count_q - 5'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         count_q <= 5'd0;
         op_q    <= 3'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy = (state_q == StRun);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: driver pushes expected HI/LO with due cycle, monitor checks.
// Honours MD_MADD_EN the same way as the design.
module tb_md_unit;

   localparam int unsigned MultN = 5;
   localparam int unsigned DivN  = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] rs_val = 32'd0;
   logic [31:0] rt_val = 32'd0;
   logic        busy;
   logic [31:0] hi, lo;

   md_unit #(.MULT_CYCLES(MultN), .DIV_CYCLES(DivN)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned t0;
      int unsigned due;
      bit          md;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc = 0;
   int unsigned busy_until = 0;
   logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
   bit          done = 1'b0;
   int          total = 0, bad = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] acc);
      longint          sa, sb2, q, r;
      longint unsigned ua, ub;
      sa  = longint'($signed(a));
      sb2 = longint'($signed(b));
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      case (o)
         3'd0: return sa * sb2;
         3'd1: return ua * ub;
         3'd2, 3'd3: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (o == 3'd2) begin
               q = sa / sb2;
               r = sa - q * sb2;
            end else begin
               q = longint'(ua / ub);
               r = longint'(ua % ub);
            end
            return {r[31:0], q[31:0]};
         end
         3'd6:    return acc + sa * sb2;
         3'd7:    return acc + ua * ub;
         default: return acc;
      endcase
   endfunction

   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] r;
      int unsigned n;
      bit          md;
      while (cyc < busy_until) begin
         @(posedge clk); #1;
      end
      start = 1'b1; op = o; rs_val = a; rt_val = b;
      @(posedge clk); #1;
      // Scramble inputs during the run; the unit must use latched values.
      start = 1'b0; op = 3'($urandom); rs_val = $urandom; rt_val = $urandom;
      md = 1'b0;
      n  = 0;
      case (o)
         3'd0, 3'd1: begin md = 1'b1; n = MultN; end
         3'd2, 3'd3: begin md = 1'b1; n = DivN; end
         3'd4: begin m_hi = a; sb.push_back('{cyc, cyc, 1'b0, m_hi, m_lo}); end
         3'd5: begin m_lo = a; sb.push_back('{cyc, cyc, 1'b0, m_hi, m_lo}); end
`ifdef MD_MADD_EN
         3'd6, 3'd7: begin md = 1'b1; n = MultN; end
`endif
         default: ;
      endcase
      if (md) begin
         r = model(o, a, b, {m_hi, m_lo});
         m_hi = r[63:32];
         m_lo = r[31:0];
         sb.push_back('{cyc, cyc + n, 1'b1, m_hi, m_lo});
         busy_until = cyc + n;
      end
   endtask

   // Present a start while busy (optionally on the completing edge); it must be ignored.
   task automatic poke(input logic [2:0] o, input logic [31:0] a, input bit at_end);
      if (cyc + 1 > busy_until) return;
      if (at_end) begin
         while (cyc + 1 < busy_until) begin
            @(posedge clk); #1;
         end
      end
      start = 1'b1; op = o; rs_val = a; rt_val = $urandom;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      sb.delete();
      m_hi = 32'd0;
      m_lo = 32'd0;
      busy_until = 0;
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   // Monitor: every cycle compares busy/hi/lo with the committed or newly-due values.
   initial begin
      logic [31:0] cur_hi, cur_lo, e_hi, e_lo;
      logic        e_busy;
      cur_hi = 32'd0;
      cur_lo = 32'd0;
      while (!done) begin
         @(negedge clk);
         if (!reset) begin
            chk("reset_busy", {31'd0, busy}, 32'd0);
            chk("reset_hi", hi, 32'd0);
            chk("reset_lo", lo, 32'd0);
            cur_hi = 32'd0;
            cur_lo = 32'd0;
         end else begin
            e_hi = cur_hi;
            e_lo = cur_lo;
            e_busy = 1'b0;
            if (sb.size() > 0) begin
               if (sb[0].due == cyc) begin
                  e_hi = sb[0].hi;
                  e_lo = sb[0].lo;
                  cur_hi = e_hi;
                  cur_lo = e_lo;
                  void'(sb.pop_front());
               end else if (sb[0].md && cyc >= sb[0].t0) begin
                  e_busy = 1'b1;
               end
            end
            chk("busy", {31'd0, busy}, {31'd0, e_busy});
            chk("hi", hi, e_hi);
            chk("lo", lo, e_lo);
         end
      end
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
      $fatal(1);
   end

   // Driver
   initial begin
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      // Reset mid-operation discards the multiply.
      issue(3'd0, 32'd3, 32'd4);
      @(posedge clk); #1;
      do_reset();
      repeat (8) @(posedge clk);
      #1;

      issue(3'd4, 32'h1111_1111, 32'd0);
      issue(3'd5, 32'h2222_2222, 32'd0);
      issue(3'd0, 32'hFFFF_FFFE, 32'd3);
      issue(3'd3, 32'd100, 32'd7);
      issue(3'd2, 32'hFFFF_FFF9, 32'd2);
      issue(3'd2, 32'h1234_5678, 32'd0);
      issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      issue(3'd3, 32'hDEAD_BEEF, 32'd0);

      issue(3'd4, 32'hAAAA_0000, 32'd0);
      issue(3'd2, 32'd1000, 32'd3);
      repeat (3) @(posedge clk);
      #1;
      poke(3'd5, 32'd5, 1'b0);
      poke(3'd4, 32'd9, 1'b1);

      issue(3'd4, 32'd0, 32'd0);
      issue(3'd5, 32'hFFFF_FFFF, 32'd0);
      issue(3'd7, 32'd1, 32'd1);
      issue(3'd6, 32'hFFFF_FFFF, 32'd2);
      repeat (MultN + 2) @(posedge clk);
      #1;

      for (int i = 0; i < 300; i++) begin
         issue(3'($urandom_range(0, 7)), pick(), pick());
         if ($urandom_range(0, 3) == 0) poke(3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 1) == 1);
         if ($urandom_range(0, 9) == 0) begin
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
         end
      end

      while (cyc < busy_until + 2) begin
         @(posedge clk); #1;
      end
      done = 1'b1;
   end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers.
- Sits in the EX stage beside the ALU and takes the forwarded rs/rt operands that EX produces.
- Gives the pipeline mult/multu/div/divu/mthi/mtlo, with mfhi/mflo reading its outputs.
- The hazard unit stalls any md instruction or mfhi/mflo in ID while the unit is busy.

Parameters:
MULT_CYCLES, 5, cycles from start to HI/LO update for mult/multu/madd/maddu (2..31)
DIV_CYCLES, 10, cycles from start to HI/LO update for div/divu (2..31)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  EX-stage md instruction valid this cycle; sampled on the rising edge
op  in  3  0=mult 1=multu 2=div 3=divu 4=mthi 5=mtlo 6=madd 7=maddu
rs_val  in  32  forwarded rs operand from EX
rt_val  in  32  forwarded rt operand from EX
busy  out  1  operation in flight
hi  out  32  HI register
lo  out  32  LO register

Behaviour:
- Reset (reset=0, any time, async): busy=0, hi=0, lo=0, counter=0, state IDLE. An operation in flight is discarded.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, down-counter active.
- IDLE + start + op in {0,1,2,3,6,7} at edge T:
  - Latch op, rs_val, rt_val.
  - Load counter with N = MULT_CYCLES (ops 0,1,6,7) or DIV_CYCLES (ops 2,3).
  - Go to RUN; busy=1 from T.
- RUN:
  - Counter decrements every edge.
  - At the edge where the counter reaches 1 → 0: write hi/lo, return to IDLE, busy=0.
  - Result is visible, with busy=0, at T+N.
- HI/LO hold their old values throughout RUN. Intermediate values are never visible.
- IDLE + start + op=4 (mthi): hi <= rs_val at edge T. Single cycle, busy stays 0, lo unchanged.
- IDLE + start + op=5 (mtlo): lo <= rs_val at edge T. Single cycle, busy stays 0, hi unchanged.
- start while busy=1: ignored, no state change. The hazard unit guarantees this never occurs; the bench checks that it is ignored.
- Arithmetic:
  - mult: {hi,lo} = signed 32x32 → 64-bit product.
  - multu: {hi,lo} = unsigned 32x32 → 64-bit product.
  - div: lo = quotient, hi = remainder, signed, truncation toward zero; remainder takes the sign of the dividend.
  - divu: same as div, unsigned.
  - 0x80000000 div 0xFFFFFFFF (signed): lo=0x80000000, hi=0.
- Divide by zero (rt_val=0, ops 2/3): hi = rs_val, lo = 0xFFFFFFFF after DIV_CYCLES. Normal latency, no exception.
- Operands and op are latched at start. Later changes on rs_val/rt_val/op during RUN have no effect.
- Hazard contract:
  - Stall the md instruction or mfhi/mflo in ID when (start | busy).
  - mfhi/mflo read hi/lo combinationally in EX.
- Back-to-back: a new start is accepted on the same edge that busy falls only if the unit is IDLE at that edge. In practice, a start accepted at T+N+1 gives result at T+N+1+N'.

Optional Feature:
- Macro: MD_MADD_EN.
- Defined:
  - op=6 (madd): {hi,lo} <= {hi,lo} + signed(rs_val*rt_val), modulo 2^64.
  - op=7 (maddu): {hi,lo} <= {hi,lo} + unsigned(rs_val*rt_val), modulo 2^64.
  - Both take MULT_CYCLES.
  - The accumulate uses the HI/LO values present at the completing edge.
- Not defined: ops 6/7 behave as NOP. They are not latched, busy stays 0, and HI/LO are unchanged.

Test Plan:
- Reset mid-operation: start mult 3*4; at cycle 2 pull reset=0 → busy=0, hi=0, lo=0 immediately. After release, no late HI/LO update occurs.
- Signed mult: start mult rs=0xFFFFFFFE (-2), rt=3 → busy=1 for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. HI/LO keep their prior values while busy.
- Unsigned and signed divide:
  - divu rs=100, rt=7 → after 10 cycles lo=14, hi=2.
  - div rs=-7 (0xFFFFFFF9), rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Divide by zero and overflow:
  - div rs=0x12345678, rt=0 → hi=0x12345678, lo=0xFFFFFFFF.
  - div rs=0x80000000, rt=0xFFFFFFFF → lo=0x80000000, hi=0.
- mthi/mtlo and ignored start:
  - mthi rs=0xAAAA0000 → hi updates next edge, busy never rises.
  - During a running div, start mtlo rs=5 → lo is not 5; final lo is the div quotient.
- MD_MADD_EN: mthi 0, mtlo 0xFFFFFFFF, then maddu rs=1, rt=1 → hi=1, lo=0 after 5 cycles. Without the macro, hi=0 and lo=0xFFFFFFFF remain and busy stays 0.
